// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one registered mux output.
// Grants are bounded by MAX_HOLD cycles and separated by a one-cycle dead slot.
module mux_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   din,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic [DATA_W-1:0]     y,
  output logic                  y_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t              state_r, state_s;
  logic [1:0]          ptr_r, ptr_s;
  logic [3:0]          hold_cnt_r, hold_s;
  logic [3:0]          gnt_s;
  logic [1:0]          sel_s;
  logic [DATA_W-1:0]   y_s, lane_s;
  logic                yv_s, busy_s;
  logic [2:0]          pick_s;

  // Returns {found, index}; search starts just after the last served requester.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  assign lane_s = din[int'(sel)*DATA_W +: DATA_W];
  assign pick_s = rr_pick(req, ptr_r);

  // Next-state and next-output decode.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    hold_s  = hold_cnt_r;
    gnt_s   = gnt;
    sel_s   = sel;
    y_s     = y;
    yv_s    = 1'b0;
    case (state_r)
      IDLE, RELEASE: begin
        if (en && pick_s[2]) begin
          state_s = GRANT;
          gnt_s   = onehot(pick_s[1:0]);
          sel_s   = pick_s[1:0];
          hold_s  = 4'd0;
        end else begin
          state_s = IDLE;
          gnt_s   = 4'd0;
        end
      end
      GRANT: begin
        // A dropped request, disable and hold expiry all collapse into one exit.
        if (!req[sel] || !en || (hold_cnt_r == HOLD_LAST)) begin
          state_s = RELEASE;
          gnt_s   = 4'd0;
          ptr_s   = sel;
          yv_s    = 1'b0;
        end else begin
          hold_s  = hold_cnt_r + 4'd1;
          y_s     = lane_s;
          yv_s    = req[sel];
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = 4'd0;
      end
    endcase
    busy_s = (state_s == GRANT);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd3;
      hold_cnt_r <= 4'd0;
      gnt        <= 4'd0;
      sel        <= 2'd0;
      y          <= '0;
      y_valid    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_s;
      gnt        <= gnt_s;
      sel        <= sel_s;
      y          <= y_s;
      y_valid    <= yv_s;
      busy       <= busy_s;
    end
  end

endmodule
